// File: rtl/seg_scan_decoder.sv
// Rebuilds the 32-bit hex word shown on an 8-digit multiplexed seven-segment scan.
// Define SEG_SCAN_DP_CAPTURE_EN to also capture the decimal points onto dp_out.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  which,
  input  logic [7:0]  seg,
  output logic [31:0] data_out,
  output logic        valid,
  output logic        update,
  output logic        seg_err,
  output logic [2:0]  err_digit,
  input  logic        err_clr
`ifdef SEG_SCAN_DP_CAPTURE_EN
  ,
  output logic [7:0]  dp_out
`endif
);

  localparam logic [2:0] ST_SYNC   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STABLE_TGT  = 4'(STABLE_FRAMES);

  logic [2:0]  state;
  logic [2:0]  which_q;
  logic [7:0]  settle_cnt;
  logic [31:0] frame_buf;
  logic [31:0] prev_frame;
  logic [7:0]  seen_mask;
  logic [3:0]  match_cnt;
  logic [3:0]  match_next;
  logic [6:0]  seg_norm;
  logic [3:0]  nibble;
  logic        glyph_ok;
  logic        change;
  logic        frame_same;
  logic        out_differs;
  logic        do_load;
  logic        sample_err;

  assign seg_norm   = SEG_ACTIVE_LOW ? ~seg[6:0] : seg[6:0];
  assign change     = (which != which_q);
  assign sample_err = (state == ST_SAMPLE) && !glyph_ok;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic       dp_norm;
  logic [7:0] frame_dp;
  logic [7:0] prev_dp;

  assign dp_norm     = SEG_ACTIVE_LOW ? ~seg[7] : seg[7];
  assign frame_same  = (frame_buf == prev_frame) && (frame_dp == prev_dp);
  assign out_differs = (frame_buf != data_out) || (frame_dp != dp_out);
`else
  logic unused_dp;

  assign unused_dp   = seg[7];
  assign frame_same  = (frame_buf == prev_frame);
  assign out_differs = (frame_buf != data_out);
`endif

  // Unrecognised patterns decode to 0 and raise glyph_ok low.
  always_comb begin
    nibble   = 4'h0;
    glyph_ok = 1'b1;
    case (seg_norm)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    match_next = 4'd1;
    if (frame_same) begin
      match_next = (match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1;
    end
    do_load = (state == ST_COMMIT) && (match_next >= STABLE_TGT) && (out_differs || !valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      which_q <= 3'd0;
    end else begin
      which_q <= which;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SYNC;
      settle_cnt <= 8'd0;
      frame_buf  <= 32'd0;
      prev_frame <= 32'd0;
      seen_mask  <= 8'd0;
      match_cnt  <= 4'd0;
      data_out   <= 32'd0;
      valid      <= 1'b0;
      update     <= 1'b0;
`ifdef SEG_SCAN_DP_CAPTURE_EN
      frame_dp   <= 8'd0;
      prev_dp    <= 8'd0;
      dp_out     <= 8'd0;
`endif
    end else begin
      update <= 1'b0;
      case (state)
        ST_SYNC: begin
          seen_mask <= 8'd0;
          if (change && (which == 3'd0)) begin
            state      <= ST_SETTLE;
            settle_cnt <= 8'd0;
          end
        end
        ST_SETTLE: begin
          if (change) begin
            settle_cnt <= 8'd0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_SAMPLE: begin
          frame_buf[{which, 2'b00} +: 4] <= nibble;
          seen_mask[which]               <= 1'b1;
`ifdef SEG_SCAN_DP_CAPTURE_EN
          frame_dp[which]                <= dp_norm;
`endif
          // Only a digit-7 sample that fills the mask closes a frame.
          if ((which == 3'd7) && (&seen_mask[6:0])) begin
            state <= ST_COMMIT;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (change) begin
            state      <= ST_SETTLE;
            settle_cnt <= 8'd0;
            if ((which == 3'd0) && !(&seen_mask)) begin
              seen_mask <= 8'd0;
            end
          end
        end
        ST_COMMIT: begin
          match_cnt <= match_next;
          if (!frame_same) begin
            prev_frame <= frame_buf;
`ifdef SEG_SCAN_DP_CAPTURE_EN
            prev_dp    <= frame_dp;
`endif
          end
          if (do_load) begin
            data_out <= frame_buf;
            valid    <= 1'b1;
            update   <= 1'b1;
`ifdef SEG_SCAN_DP_CAPTURE_EN
            dp_out   <= frame_dp;
`endif
          end
          seen_mask <= 8'd0;
          state     <= ST_HOLD;
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

  // A fresh error beats a simultaneous clear and records its own digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_err   <= 1'b0;
      err_digit <= 3'd0;
    end else if (sample_err) begin
      seg_err <= 1'b1;
      if (!seg_err || err_clr) begin
        err_digit <= which;
      end
    end else if (err_clr) begin
      seg_err   <= 1'b0;
      err_digit <= 3'd0;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a frame-level model predicts each confirmed value.
// Builds with or without SEG_SCAN_DP_CAPTURE_EN.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int SF     = 2;
  localparam int DMIN   = SETTLE + 3;
  localparam int DMAX   = SETTLE + 12;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic        err_clr;
  logic [31:0] data_out;
  logic        valid;
  logic        update;
  logic        seg_err;
  logic [2:0]  err_digit;
`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic [7:0]  dp_out;
`endif

  logic [6:0] glyphTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t        expQ [$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mLast;
  logic [7:0]  mLastDp;
  int          mRun;
  logic [31:0] mConf;
  logic [7:0]  mConfDp;
  bit          mConfValid;
  bit          mErr;
  logic [2:0]  mErrDigit;

  seg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .STABLE_FRAMES (SF),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .which    (which),
    .seg      (seg),
    .data_out (data_out),
    .valid    (valid),
    .update   (update),
    .seg_err  (seg_err),
    .err_digit(err_digit),
    .err_clr  (err_clr)
`ifdef SEG_SCAN_DP_CAPTURE_EN
    ,
    .dp_out   (dp_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit isGlyph(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (glyphTab[i] == p) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [6:0] randomBadPattern();
    logic [6:0] p;
    p = 7'($urandom);
    while (isGlyph(p)) p = 7'($urandom);
    return p;
  endfunction

  // Active-low drive: a lit segment (or dp) is a 0 on the wire.
  function automatic logic [7:0] encodeSeg(input logic [6:0] lit, input logic dpLit);
    return ~{dpLit, lit};
  endfunction

  task automatic modelReset();
    expQ.delete();
    mLast      = 32'd0;
    mLastDp    = 8'd0;
    mRun       = 0;
    mConf      = 32'd0;
    mConfDp    = 8'd0;
    mConfValid = 1'b0;
    mErr       = 1'b0;
    mErrDigit  = 3'd0;
  endtask

  // A complete frame extends or restarts the run of identical frames;
  // a long enough run showing something new becomes the next confirmed value.
  task automatic modelFrame(input logic [31:0] frameVal, input logic [7:0] frameDp);
    logic [7:0] dpEff;
    exp_t       e;
`ifdef SEG_SCAN_DP_CAPTURE_EN
    dpEff = frameDp;
`else
    dpEff = 8'd0 & frameDp;
`endif
    if (frameVal == mLast && dpEff == mLastDp) begin
      mRun = (mRun < 15) ? mRun + 1 : 15;
    end else begin
      mRun    = 1;
      mLast   = frameVal;
      mLastDp = dpEff;
    end
    if (mRun >= SF && (!mConfValid || frameVal != mConf || dpEff != mConfDp)) begin
      e.data     = frameVal;
      e.dp       = dpEff;
      expQ.push_back(e);
      mConf      = frameVal;
      mConfDp    = dpEff;
      mConfValid = 1'b1;
    end
  endtask

  task automatic driveDigit(input int d, input logic [6:0] lit, input logic dpLit, input int dwell);
    which = 3'(d);
    seg   = encodeSeg(lit, dpLit);
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  // Scans one frame: digit 0 first, digit 7 last, middle digits optionally shuffled.
  task automatic applyStimulus(input logic [31:0] value, input logic [7:0] dpBits,
                               input logic [7:0] badMask, input bit blankBad,
                               input int minDwell, input int maxDwell,
                               input bit shuffle, input bit counts);
    int          order [8];
    int          j;
    int          tmp;
    int          d;
    logic [31:0] shown;
    logic [6:0]  lit;
    shown = value;
    for (int i = 0; i < 8; i++) begin
      order[i] = i;
      if (badMask[i]) shown[i*4 +: 4] = 4'h0;
    end
    if (shuffle) begin
      for (int i = 6; i >= 2; i--) begin
        j        = $urandom_range(i, 1);
        tmp      = order[i];
        order[i] = order[j];
        order[j] = tmp;
      end
    end
    if (counts) modelFrame(shown, dpBits);
    for (int k = 0; k < 8; k++) begin
      d = order[k];
      if (badMask[d]) begin
        lit = blankBad ? 7'h00 : randomBadPattern();
        if (!mErr) begin
          mErr      = 1'b1;
          mErrDigit = 3'(d);
        end
      end else begin
        lit = glyphTab[value[d*4 +: 4]];
      end
      driveDigit(d, lit, dpBits[d], $urandom_range(maxDwell, minDwell));
    end
    if (counts) begin
      checkOutput("seg_err", {31'd0, seg_err}, {31'd0, mErr});
      checkOutput("err_digit", {29'd0, err_digit}, {29'd0, mErrDigit});
    end
  endtask

  task automatic errClear();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr   = 1'b0;
    mErr      = 1'b0;
    mErrDigit = 3'd0;
    checkOutput("seg_err_clr", {31'd0, seg_err}, 32'd0);
    checkOutput("err_digit_clr", {29'd0, err_digit}, 32'd0);
  endtask

  task automatic checkConfirmed(input string name);
    checkOutput({name, "_data"}, data_out, mConf);
    checkOutput({name, "_valid"}, {31'd0, valid}, {31'd0, mConfValid});
  endtask

  // Monitor: every update pulse must match the oldest predicted confirmation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && update === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_update: got data_out %h with nothing expected at %0t", data_out, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("upd_data_out", data_out, e.data);
        checkOutput("upd_valid", {31'd0, valid}, 32'd1);
`ifdef SEG_SCAN_DP_CAPTURE_EN
        checkOutput("upd_dp_out", {24'd0, dp_out}, {24'd0, e.dp});
`endif
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  bad;
    int          reps;
    modelReset();
    rst_n   = 1'b0;
    which   = 3'd7;
    seg     = 8'hFF;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_data_out", data_out, 32'd0);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_update", {31'd0, update}, 32'd0);
    checkOutput("rst_seg_err", {31'd0, seg_err}, 32'd0);
    checkOutput("rst_err_digit", {29'd0, err_digit}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] short dwell frames");
    repeat (3) applyStimulus(32'h13579BDF, 8'h00, 8'h00, 1'b0, 2, 2, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("short_valid", {31'd0, valid}, 32'd0);
    checkOutput("short_data", data_out, 32'd0);

    $display("[TB] FEDCBA98 confirmation");
    repeat (2) applyStimulus(32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 64, 64, 1'b0, 1'b1);
    checkConfirmed("fedc");
    applyStimulus(32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 64, 64, 1'b0, 1'b1);

    $display("[TB] switch to 76543210");
    applyStimulus(32'h7654BA98, 8'h00, 8'h00, 1'b0, DMIN, DMAX, 1'b0, 1'b1);
    applyStimulus(32'h76543210, 8'h00, 8'h00, 1'b0, DMIN, DMAX, 1'b0, 1'b1);
    checkOutput("hold_old", data_out, 32'hFEDCBA98);
    applyStimulus(32'h76543210, 8'h00, 8'h00, 1'b0, DMIN, DMAX, 1'b0, 1'b1);
    checkConfirmed("7654");

    $display("[TB] blank digit 3");
    repeat (2) applyStimulus(32'h12345678, 8'h00, 8'h08, 1'b1, DMIN, DMAX, 1'b1, 1'b1);
    checkConfirmed("blank");
    errClear();

`ifdef SEG_SCAN_DP_CAPTURE_EN
    $display("[TB] dp capture");
    repeat (2) applyStimulus(32'h0BADF00D, 8'h21, 8'h00, 1'b0, DMIN, DMAX, 1'b1, 1'b1);
    checkConfirmed("dp");
    checkOutput("dp_out", {24'd0, dp_out}, 32'h21);
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 14; n++) begin
      v    = $urandom;
      reps = $urandom_range(3, 1);
      bad  = ($urandom_range(3, 0) == 0) ? 8'(8'h01 << $urandom_range(7, 0)) : 8'h00;
      for (int r = 0; r < reps; r++) begin
        applyStimulus(v, 8'($urandom), bad, 1'b0, DMIN, DMAX, 1'b1, 1'b1);
        if ($urandom_range(4, 0) == 0) errClear();
      end
    end
    checkConfirmed("random");

    $display("[TB] reset mid-frame");
    repeat (4) @(posedge clk);
    #1;
    checkOutput("drained_before_reset", 32'(expQ.size()), 32'd0);
    for (int d = 0; d < 3; d++) driveDigit(d, glyphTab[d], 1'b0, DMIN);
    driveDigit(3, glyphTab[3], 1'b0, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_data_out", data_out, 32'd0);
    checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
    checkOutput("midrst_seg_err", {31'd0, seg_err}, 32'd0);
    checkOutput("midrst_err_digit", {29'd0, err_digit}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int d = 4; d < 8; d++) driveDigit(d, glyphTab[d], 1'b0, DMIN);
    applyStimulus(32'hA5A5C3C3, 8'h00, 8'h00, 1'b0, DMIN, DMAX, 1'b0, 1'b1);
    checkOutput("post_rst_valid", {31'd0, valid}, 32'd0);
    applyStimulus(32'hA5A5C3C3, 8'h00, 8'h00, 1'b0, DMIN, DMAX, 1'b1, 1'b1);
    checkConfirmed("post_rst");

    repeat (20) @(posedge clk);
    #1;
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
